tt_host_port: RTL and testbench

Parametrised host-side byte port for the coprocessor tile, sitting between the top-level pin wrapper (ui_in/uio_in/uo_out) and the coprocessor core. Generalises the fixed single-byte readout/sayhi pin controls to a bank of NUM_REGS words of WORD_W bits. Words are loaded byte-serially from the host, streamed back byte-serially on readout, and updated by the core with results. A "hi" identification burst is also supported.

---
 rtl/tt_host_pkg.sv | 21 ++
 rtl/tt_host_regfile.sv | 61 ++++++
 rtl/tt_host_port.sv | 222 ++++++++++++++++++++++
 tb/tb_tt_host_port.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_host_pkg.sv
// tt_host_pkg: shared types and constants for the host byte port.
//   host_state_t : controller state encoding
//   HI_BYTE0/1   : identification burst bytes ("h", "i")
//   byte_count() : number of bytes in a register word
package tt_host_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        READ = 2'd2,
        HI   = 2'd3
    } host_state_t;

    localparam logic [7:0] HI_BYTE0 = 8'h68;
    localparam logic [7:0] HI_BYTE1 = 8'h69;

    function automatic int byte_count(input int word_w);
        return word_w / 8;
    endfunction

endpackage

// File: rtl/tt_host_regfile.sv
// tt_host_regfile: NUM_REGS x WORD_W register bank for the host port.
// Ports:
//   clk, rst              clock, synchronous active-high reset (clears all words)
//   host_we/addr/data     host commit port (always wins)
//   res_we/addr/data      core result port
//   rd_addr / rd_data     asynchronous read, with same-cycle write bypass
//   res_lost              result write to the same index as a host commit this cycle
module tt_host_regfile
    import tt_host_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int NUM_REGS = 4,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_we,
    input  logic [AW-1:0]     host_addr,
    input  logic [WORD_W-1:0] host_data,
    input  logic              res_we,
    input  logic [AW-1:0]     res_addr,
    input  logic [WORD_W-1:0] res_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic              res_lost
);

    logic [WORD_W-1:0] mem [NUM_REGS];
    logic              res_commit;

    assign res_lost   = res_we && host_we && (res_addr == host_addr);
    assign res_commit = res_we && !res_lost;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (res_commit) begin
                mem[res_addr] <= res_data;
            end
            if (host_we) begin
                mem[host_addr] <= host_data;
            end
        end
    end

    // Bypass writes landing on this edge so a readout accepted on the same
    // edge as a result write already sees the new word.
    always_comb begin
        rd_data = mem[rd_addr];
        if (res_commit && (res_addr == rd_addr)) begin
            rd_data = res_data;
        end
        if (host_we && (host_addr == rd_addr)) begin
            rd_data = host_data;
        end
    end

endmodule

// File: rtl/tt_host_port.sv
// tt_host_port: host-side byte port for the coprocessor tile.
// Loads words byte-serially (LSB first) into a register bank, streams a
// snapshot of a word back byte-serially, emits an "hi" burst, and accepts
// core result writes with host-priority collision handling.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ena                         tile select; low freezes the controller
//   data_in, addr               host byte and register select
//   load, readout, sayhi        host commands (priority sayhi > readout > load)
//   data_out, out_valid         registered stream byte and its qualifier
//   busy                        command in progress
//   wr_valid/wr_addr/wr_data    committed host word (one-cycle pulse)
//   res_valid/res_addr/res_data core result write
//   res_drop                    one-cycle pulse when a result loses a collision
//
// state | meaning
// IDLE  | waiting for a command
// LOAD  | collecting bytes 1..BYTES-1 of a host word
// READ  | streaming the snapshot, cnt = byte currently on data_out
// HI    | streaming the identification burst
module tt_host_port
    import tt_host_pkg::*;
#(
    parameter  int WORD_W   = 32,
    parameter  int NUM_REGS = 4,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [7:0]        data_in,
    input  logic [AW-1:0]     addr,
    input  logic              load,
    input  logic              readout,
    input  logic              sayhi,
    output logic [7:0]        data_out,
    output logic              out_valid,
    output logic              busy,
    output logic              wr_valid,
    output logic [AW-1:0]     wr_addr,
    output logic [WORD_W-1:0] wr_data,
    input  logic              res_valid,
    input  logic [AW-1:0]     res_addr,
    input  logic [WORD_W-1:0] res_data,
    output logic              res_drop
);

    localparam int             BYTES = byte_count(WORD_W);
    localparam int             CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CW-1:0]  LAST  = CW'(BYTES - 1);

    host_state_t       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [AW-1:0]     load_addr_q, load_addr_d;
    logic [7:0]        data_out_q, data_out_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              wr_valid_q, wr_valid_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
    logic              res_drop_q;

    logic              host_we;
    logic [AW-1:0]     host_addr;
    logic [WORD_W-1:0] asm_word;
    logic [WORD_W-1:0] rd_data;
    logic              res_lost;
    int                byte_idx;

    tt_host_regfile #(
        .WORD_W   (WORD_W),
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_data (asm_word),
        .res_we    (res_valid),
        .res_addr  (res_addr),
        .res_data  (res_data),
        .rd_addr   (addr),
        .rd_data   (rd_data),
        .res_lost  (res_lost)
    );

    // Word as it would look with data_in placed at the current byte slot;
    // a fresh load starts from zero so stale snapshot bits never leak in.
    always_comb begin
        byte_idx = (state_q == IDLE) ? 0 : int'(cnt_q);
        asm_word = (state_q == IDLE) ? '0 : shreg_q;
        asm_word[byte_idx*8 +: 8] = data_in;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        load_addr_d = load_addr_q;
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        host_we     = 1'b0;
        host_addr   = load_addr_q;

        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (sayhi) begin
                        state_d     = HI;
                        cnt_d       = '0;
                        data_out_d  = HI_BYTE0;
                        out_valid_d = 1'b1;
                    end else if (readout) begin
                        state_d     = READ;
                        cnt_d       = '0;
                        data_out_d  = rd_data[7:0];
                        shreg_d     = rd_data >> 8;
                        out_valid_d = 1'b1;
                    end else if (load) begin
                        load_addr_d = addr;
                        if (BYTES == 1) begin
                            host_we    = 1'b1;
                            host_addr  = addr;
                            wr_valid_d = 1'b1;
                            wr_addr_d  = addr;
                            wr_data_d  = asm_word;
                        end else begin
                            state_d = LOAD;
                            shreg_d = asm_word;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                LOAD: begin
                    if (load) begin
                        if (cnt_q == LAST) begin
                            host_we    = 1'b1;
                            wr_valid_d = 1'b1;
                            wr_addr_d  = load_addr_q;
                            wr_data_d  = asm_word;
                            state_d    = IDLE;
                            cnt_d      = '0;
                        end else begin
                            shreg_d = asm_word;
                            cnt_d   = cnt_q + CW'(1);
                        end
                    end
                end
                READ: begin
                    if (cnt_q == LAST) begin
                        state_d     = IDLE;
                        cnt_d       = '0;
                        data_out_d  = 8'h00;
                        out_valid_d = 1'b0;
                    end else begin
                        data_out_d = shreg_q[7:0];
                        shreg_d    = shreg_q >> 8;
                        cnt_d      = cnt_q + CW'(1);
                    end
                end
                HI: begin
                    if (cnt_q == '0) begin
                        data_out_d = HI_BYTE1;
                        cnt_d      = CW'(1);
                    end else begin
                        state_d     = IDLE;
                        cnt_d       = '0;
                        data_out_d  = 8'h00;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            load_addr_q <= '0;
            data_out_q  <= 8'h00;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            res_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            load_addr_q <= load_addr_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            res_drop_q  <= res_lost;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign res_drop  = res_drop_q;

endmodule

// File: tb/tb_tt_host_port.sv
// Bench for tt_host_port: directed scenarios plus randomized command mix on
// a 32-bit x 4 instance, checked against a word-level model; a small
// 8-bit x 2 instance checks single-byte latencies.
module tb_tt_host_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [7:0]  data_in;
    logic [1:0]  addr;
    logic        load, readout, sayhi;
    logic [7:0]  data_out;
    logic        out_valid, busy, wr_valid;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic        res_valid;
    logic [1:0]  res_addr;
    logic [31:0] res_data;
    logic        res_drop;

    logic        s_ena;
    logic [7:0]  s_data_in;
    logic [0:0]  s_addr;
    logic        s_load, s_readout, s_sayhi;
    logic [7:0]  s_data_out;
    logic        s_out_valid, s_busy, s_wr_valid;
    logic [0:0]  s_wr_addr;
    logic [7:0]  s_wr_data;
    logic        s_res_valid;
    logic [0:0]  s_res_addr;
    logic [7:0]  s_res_data;
    logic        s_res_drop;

    int errors = 0;
    int checks = 0;
    logic [31:0] mdl [4];

    always #5 clk = ~clk;

    tt_host_port #(.WORD_W(32), .NUM_REGS(4)) dut (
        .clk(clk), .rst(rst), .ena(ena), .data_in(data_in), .addr(addr),
        .load(load), .readout(readout), .sayhi(sayhi),
        .data_out(data_out), .out_valid(out_valid), .busy(busy),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .res_valid(res_valid), .res_addr(res_addr), .res_data(res_data),
        .res_drop(res_drop)
    );

    tt_host_port #(.WORD_W(8), .NUM_REGS(2)) dut_small (
        .clk(clk), .rst(rst), .ena(s_ena), .data_in(s_data_in), .addr(s_addr),
        .load(s_load), .readout(s_readout), .sayhi(s_sayhi),
        .data_out(s_data_out), .out_valid(s_out_valid), .busy(s_busy),
        .wr_valid(s_wr_valid), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .res_valid(s_res_valid), .res_addr(s_res_addr), .res_data(s_res_data),
        .res_drop(s_res_drop)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock edge; the model applies the host commit and result write
    // that the DUT should perform on this edge.
    task automatic tick(input bit commit, input logic [1:0] caddr, input logic [31:0] cword);
        bit coll;
        coll = !rst && commit && res_valid && (res_addr == caddr);
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 4; i++) mdl[i] = '0;
        end else begin
            if (commit) mdl[caddr] = cword;
            if (res_valid && !coll) mdl[res_addr] = res_data;
        end
        chk("res_drop", {63'd0, res_drop}, {63'd0, coll});
    endtask

    task automatic rand_res(input bit rnd);
        res_valid = rnd && ($urandom_range(0, 3) == 0);
        res_addr  = 2'($urandom_range(0, 3));
        res_data  = $urandom;
    endtask

    task automatic clear_cmds();
        load = 0; readout = 0; sayhi = 0; res_valid = 0; ena = 1;
    endtask

    task automatic idle(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            clear_cmds();
            rand_res(rnd);
            tick(0, 0, 0);
            chk("idle_out_valid", {63'd0, out_valid}, 0);
            chk("idle_busy", {63'd0, busy}, 0);
            chk("idle_wr_valid", {63'd0, wr_valid}, 0);
        end
        res_valid = 0;
    endtask

    task automatic do_load(input logic [1:0] a, input logic [31:0] w, input int stall1,
                           input bit rnd, input bit fres, input logic [1:0] fra,
                           input logic [31:0] frd);
        int n;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                n = rnd ? $urandom_range(0, 2) : ((k == 2) ? stall1 : 0);
                for (int s = 0; s < n; s++) begin
                    load = 0; data_in = 8'($urandom);
                    readout = rnd && $urandom_range(0, 1) == 1;
                    sayhi = rnd && $urandom_range(0, 3) == 0;
                    rand_res(rnd);
                    tick(0, 0, 0);
                    chk("stall_busy", {63'd0, busy}, 1);
                    chk("stall_wr_valid", {63'd0, wr_valid}, 0);
                end
            end
            load = 1;
            data_in = w[k*8 +: 8];
            addr = (k == 0 || !rnd) ? a : 2'($urandom_range(0, 3));
            readout = (k > 0) && rnd && $urandom_range(0, 1) == 1;
            sayhi = (k > 0) && rnd && $urandom_range(0, 3) == 0;
            rand_res(rnd);
            if (k == 3 && fres) begin
                res_valid = 1; res_addr = fra; res_data = frd;
            end
            tick(k == 3, a, w);
            clear_cmds();
            if (k < 3) begin
                chk("load_busy", {63'd0, busy}, 1);
                chk("load_wr_valid", {63'd0, wr_valid}, 0);
            end else begin
                chk("wr_valid", {63'd0, wr_valid}, 1);
                chk("wr_addr", {62'd0, wr_addr}, {62'd0, a});
                chk("wr_data", {32'd0, wr_data}, {32'd0, w});
                chk("load_done_busy", {63'd0, busy}, 0);
            end
        end
    endtask

    task automatic do_read(input logic [1:0] a, input int hold_at, input int hold_len,
                           input bit rnd, input bit res_mid, input logic [31:0] mid_data);
        logic [31:0] snap;
        int idx, cyc;
        bit e;
        readout = 1; addr = a;
        load = rnd && $urandom_range(0, 1) == 1;
        data_in = 8'($urandom);
        rand_res(rnd);
        tick(0, 0, 0);
        clear_cmds();
        snap = mdl[a];
        idx = 0; cyc = 0;
        while (idx < 4 && cyc < 200) begin
            chk("rd_out_valid", {63'd0, out_valid}, 1);
            chk("rd_byte", {56'd0, data_out}, {56'd0, snap[idx*8 +: 8]});
            chk("rd_busy", {63'd0, busy}, 1);
            e = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= hold_at && cyc < hold_at + hold_len);
            if (hold_at < 0 && !rnd) e = 1;
            ena = e;
            readout = rnd && $urandom_range(0, 1) == 1;
            sayhi = rnd && $urandom_range(0, 3) == 0;
            load = rnd && $urandom_range(0, 1) == 1;
            addr = 2'($urandom_range(0, 3));
            rand_res(rnd);
            if (res_mid && cyc == 1) begin
                res_valid = 1; res_addr = a; res_data = mid_data;
            end
            tick(0, 0, 0);
            if (e) idx++;
            cyc++;
        end
        clear_cmds();
        chk("rd_done", idx, 4);
        chk("rd_end_out_valid", {63'd0, out_valid}, 0);
        chk("rd_end_data_out", {56'd0, data_out}, 0);
        chk("rd_end_busy", {63'd0, busy}, 0);
    endtask

    task automatic do_hi(input bit junk);
        sayhi = 1; readout = junk; load = junk;
        data_in = 8'($urandom); addr = 2'($urandom_range(0, 3));
        rand_res(junk);
        tick(0, 0, 0);
        clear_cmds();
        chk("hi0_byte", {56'd0, data_out}, 64'h68);
        chk("hi0_valid", {63'd0, out_valid}, 1);
        chk("hi0_busy", {63'd0, busy}, 1);
        chk("hi0_no_wr", {63'd0, wr_valid}, 0);
        rand_res(junk);
        tick(0, 0, 0);
        clear_cmds();
        chk("hi1_byte", {56'd0, data_out}, 64'h69);
        chk("hi1_valid", {63'd0, out_valid}, 1);
        chk("hi1_busy", {63'd0, busy}, 1);
        tick(0, 0, 0);
        chk("hi_end_valid", {63'd0, out_valid}, 0);
        chk("hi_end_data", {56'd0, data_out}, 0);
        chk("hi_end_busy", {63'd0, busy}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1; clear_cmds(); data_in = 0; addr = 0; res_addr = 0; res_data = 0;
        s_ena = 1; s_data_in = 0; s_addr = 0; s_load = 0; s_readout = 0; s_sayhi = 0;
        s_res_valid = 0; s_res_addr = 0; s_res_data = 0;
        for (int i = 0; i < 4; i++) mdl[i] = '0;
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("rst_data_out", {56'd0, data_out}, 0);
        chk("rst_out_valid", {63'd0, out_valid}, 0);
        chk("rst_busy", {63'd0, busy}, 0);
        chk("rst_wr_valid", {63'd0, wr_valid}, 0);
        chk("rst_wr_addr", {62'd0, wr_addr}, 0);
        chk("rst_wr_data", {32'd0, wr_data}, 0);
        rst = 0;
        idle(2, 0);

        do_hi(1);
        do_load(2, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        do_read(2, -1, 0, 0, 0, 0);
        do_load(1, 32'h12345678, 3, 0, 0, 0, 0);
        do_read(1, -1, 0, 0, 0, 0);

        // reset in the middle of a load
        load = 1; addr = 3; data_in = 8'h11; tick(0, 0, 0);
        data_in = 8'h22; tick(0, 0, 0);
        clear_cmds(); rst = 1; tick(0, 0, 0); rst = 0;
        chk("rst_load_busy", {63'd0, busy}, 0);
        chk("rst_load_wr_valid", {63'd0, wr_valid}, 0);
        idle(1, 0);
        do_read(3, -1, 0, 0, 0, 0);

        do_load(1, 32'hCAFEF00D, 0, 0, 1, 1, 32'h11111111);
        do_read(1, -1, 0, 0, 0, 0);
        do_load(1, 32'hA5A5A5A5, 0, 0, 1, 3, 32'h33333333);
        do_read(1, -1, 0, 0, 0, 0);
        do_read(3, -1, 0, 0, 0, 0);

        do_load(0, 32'h01020304, 0, 0, 0, 0, 0);
        do_read(0, -1, 0, 0, 1, 32'hFFEEDDCC);
        do_read(0, -1, 0, 0, 0, 0);
        do_load(2, 32'h89ABCDEF, 0, 0, 0, 0, 0);
        do_read(2, 1, 4, 0, 0, 0);

        // reset mid-stream
        readout = 1; addr = 2; tick(0, 0, 0); clear_cmds();
        tick(0, 0, 0);
        rst = 1; tick(0, 0, 0); rst = 0;
        chk("rst_stream_valid", {63'd0, out_valid}, 0);
        chk("rst_stream_busy", {63'd0, busy}, 0);
        idle(1, 0);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0: do_load(2'($urandom_range(0, 3)), $urandom, 0, 1, 0, 0, 0);
                1, 2: do_read(2'($urandom_range(0, 3)), -1, 0, 1, 0, 0);
                default: do_hi(1);
            endcase
            idle($urandom_range(0, 2), 1);
        end

        // single-byte instance
        s_load = 1; s_addr = 1; s_data_in = 8'hA5; tick(0, 0, 0);
        s_load = 0;
        chk("s_wr_valid", {63'd0, s_wr_valid}, 1);
        chk("s_wr_addr", {63'd0, s_wr_addr}, 1);
        chk("s_wr_data", {56'd0, s_wr_data}, 64'hA5);
        chk("s_load_busy", {63'd0, s_busy}, 0);
        s_readout = 1; tick(0, 0, 0); s_readout = 0;
        chk("s_rd_valid", {63'd0, s_out_valid}, 1);
        chk("s_rd_byte", {56'd0, s_data_out}, 64'hA5);
        chk("s_rd_busy", {63'd0, s_busy}, 1);
        tick(0, 0, 0);
        chk("s_rd_end_valid", {63'd0, s_out_valid}, 0);
        chk("s_rd_end_busy", {63'd0, s_busy}, 0);
        s_res_valid = 1; s_res_addr = 0; s_res_data = 8'h3C; s_readout = 1; s_addr = 0;
        tick(0, 0, 0);
        s_res_valid = 0; s_readout = 0;
        chk("s_fwd_byte", {56'd0, s_data_out}, 64'h3C);
        tick(0, 0, 0);
        s_load = 1; s_addr = 0; s_data_in = 8'h5A;
        s_res_valid = 1; s_res_addr = 0; s_res_data = 8'hFF;
        tick(0, 0, 0);
        s_load = 0; s_res_valid = 0;
        chk("s_coll_wr_data", {56'd0, s_wr_data}, 64'h5A);
        chk("s_coll_drop", {63'd0, s_res_drop}, 1);
        s_readout = 1; tick(0, 0, 0); s_readout = 0;
        chk("s_coll_rd", {56'd0, s_data_out}, 64'h5A);
        chk("s_drop_pulse", {63'd0, s_res_drop}, 0);
        tick(0, 0, 0);
        s_sayhi = 1; tick(0, 0, 0); s_sayhi = 0;
        chk("s_hi0", {56'd0, s_data_out}, 64'h68);
        tick(0, 0, 0);
        chk("s_hi1", {56'd0, s_data_out}, 64'h69);
        tick(0, 0, 0);
        chk("s_hi_busy", {63'd0, s_busy}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
